// File: rtl/branch_resolve_pipe_if.sv
// ----------------------------------------------------------------------------
// branch_resolve_pipe_if
//   Bundles the pipeline-facing signals of branch_resolve_pipe.
//   master : pipeline / hazard-unit side (drives D/E inputs, consumes results)
//   slave  : branch_resolve_pipe side
//   Signals:
//     branchD, pred_takeD, pcD, targetD : branch info from Decode
//     stallE, stallM, flushE            : hazard-unit controls
//     condE                             : actual condition resolved in Execute
//     branchM, pred_takeM, actual_takeM,
//     pcM                               : M-stage predictor feedback
//     mispredM, redirect_pcM            : mispredict indication and fix-up PC
//     flush_predD, flush_predE          : wrong-path flushes
//     branch_cnt, mispred_cnt           : saturating statistics
// ----------------------------------------------------------------------------
interface branch_resolve_pipe_if #(
  parameter int unsigned CNT_W = 32
);
  logic             branchD;
  logic             pred_takeD;
  logic [31:0]      pcD;
  logic [31:0]      targetD;
  logic             stallE;
  logic             stallM;
  logic             flushE;
  logic             condE;

  logic             branchM;
  logic             pred_takeM;
  logic             actual_takeM;
  logic [31:0]      pcM;
  logic             mispredM;
  logic [31:0]      redirect_pcM;
  logic             flush_predD;
  logic             flush_predE;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output branchD, pred_takeD, pcD, targetD, stallE, stallM, flushE, condE,
    input  branchM, pred_takeM, actual_takeM, pcM, mispredM, redirect_pcM,
           flush_predD, flush_predE, branch_cnt, mispred_cnt
  );

  modport slave (
    input  branchD, pred_takeD, pcD, targetD, stallE, stallM, flushE, condE,
    output branchM, pred_takeM, actual_takeM, pcM, mispredM, redirect_pcM,
           flush_predD, flush_predE, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_pipe.sv
// ----------------------------------------------------------------------------
// branch_resolve_pipe
//   Carries each branch's prediction from Decode through Execute into Memory,
//   resolves it in M, drives the wrong-path flush / PC redirect and keeps
//   saturating retired-branch and mispredict counters.
//   Ports:
//     clk  : clock, all state on the rising edge
//     rst  : synchronous active-high reset
//     bus  : branch_resolve_pipe_if.slave (see interface header)
//   Parameter:
//     CNT_W : width of branch_cnt / mispred_cnt (must match the interface)
// ----------------------------------------------------------------------------
module branch_resolve_pipe #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_pipe_if.slave  bus
);

  // D/E register
  logic        validE_q,  validE_d;
  logic        predE_q,   predE_d;
  logic [31:0] pcE_q,     pcE_d;
  logic [31:0] targetE_q, targetE_d;

  // E/M register
  logic        branchM_q,   branchM_d;
  logic        predM_q,     predM_d;
  logic        actM_q,      actM_d;
  logic [31:0] pcM_q,       pcM_d;
  logic [31:0] targetM_q,   targetM_d;
  logic [31:0] pc4M_q,      pc4M_d;

  // Statistics
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  logic mispred;
  logic retire;
  logic stall_de;

  assign mispred  = branchM_q & (predM_q ^ actM_q);
  assign retire   = branchM_q & ~bus.stallM;
  assign stall_de = bus.stallE | bus.stallM;

  // D/E next state: a mispredict squashes the E slot even when the D/E
  // register would otherwise be stalled, since whatever sits there is wrong-path.
  always_comb begin
    validE_d  = validE_q;
    predE_d   = predE_q;
    pcE_d     = pcE_q;
    targetE_d = targetE_q;
    if (mispred || bus.flushE) begin
      validE_d  = 1'b0;
      predE_d   = 1'b0;
      pcE_d     = '0;
      targetE_d = '0;
    end else if (!stall_de) begin
      validE_d  = bus.branchD;
      // Non-branches never carry a taken prediction.
      predE_d   = bus.branchD & bus.pred_takeD;
      pcE_d     = bus.pcD;
      targetE_d = bus.targetD;
    end
  end

  // E/M next state: stallM outranks the mispredict bubble so the resolved
  // branch stays visible in M (and keeps flushing) until it can retire.
  always_comb begin
    branchM_d = branchM_q;
    predM_d   = predM_q;
    actM_d    = actM_q;
    pcM_d     = pcM_q;
    targetM_d = targetM_q;
    pc4M_d    = pc4M_q;
    if (!bus.stallM) begin
      if (mispred) begin
        branchM_d = 1'b0;
        predM_d   = 1'b0;
        actM_d    = 1'b0;
        pcM_d     = '0;
        targetM_d = '0;
        pc4M_d    = '0;
      end else begin
        branchM_d = validE_q;
        predM_d   = predE_q;
        actM_d    = bus.condE & validE_q;
        pcM_d     = pcE_q;
        targetM_d = targetE_q;
        pc4M_d    = pcE_q + 32'd4;
      end
    end
  end

  // Counters advance only on the retiring edge, so a stalled branch is
  // counted once; both stick at all-ones.
  always_comb begin
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (retire) begin
      if (bcnt_q != '1) bcnt_d = bcnt_q + 1'b1;
      if (mispred && (mcnt_q != '1)) mcnt_d = mcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      validE_q  <= 1'b0;
      predE_q   <= 1'b0;
      pcE_q     <= '0;
      targetE_q <= '0;
      branchM_q <= 1'b0;
      predM_q   <= 1'b0;
      actM_q    <= 1'b0;
      pcM_q     <= '0;
      targetM_q <= '0;
      pc4M_q    <= '0;
      bcnt_q    <= '0;
      mcnt_q    <= '0;
    end else begin
      validE_q  <= validE_d;
      predE_q   <= predE_d;
      pcE_q     <= pcE_d;
      targetE_q <= targetE_d;
      branchM_q <= branchM_d;
      predM_q   <= predM_d;
      actM_q    <= actM_d;
      pcM_q     <= pcM_d;
      targetM_q <= targetM_d;
      pc4M_q    <= pc4M_d;
      bcnt_q    <= bcnt_d;
      mcnt_q    <= mcnt_d;
    end
  end

  assign bus.branchM      = branchM_q;
  assign bus.pred_takeM   = predM_q;
  assign bus.actual_takeM = actM_q;
  assign bus.pcM          = pcM_q;
  assign bus.mispredM     = mispred;
  assign bus.redirect_pcM = actM_q ? targetM_q : pc4M_q;
  assign bus.flush_predD  = mispred;
  assign bus.flush_predE  = mispred;
  assign bus.branch_cnt   = bcnt_q;
  assign bus.mispred_cnt  = mcnt_q;

endmodule

// File: tb/tb_branch_resolve_pipe.sv
module tb_branch_resolve_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        branchD, pred_takeD, stallE, stallM, flushE, condE;
  logic [31:0] pcD, targetD;

  branch_resolve_pipe_if #(.CNT_W(32)) bus32 ();
  branch_resolve_pipe_if #(.CNT_W(4))  bus4  ();

  assign bus32.branchD = branchD;    assign bus4.branchD = branchD;
  assign bus32.pred_takeD = pred_takeD; assign bus4.pred_takeD = pred_takeD;
  assign bus32.pcD = pcD;            assign bus4.pcD = pcD;
  assign bus32.targetD = targetD;    assign bus4.targetD = targetD;
  assign bus32.stallE = stallE;      assign bus4.stallE = stallE;
  assign bus32.stallM = stallM;      assign bus4.stallM = stallM;
  assign bus32.flushE = flushE;      assign bus4.flushE = flushE;
  assign bus32.condE = condE;        assign bus4.condE = condE;

  branch_resolve_pipe #(.CNT_W(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
  branch_resolve_pipe #(.CNT_W(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4));

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: one instruction slot per stage, moved according to
  // the stage rules; counters are plain integers clipped at their maxima.
  typedef struct {
    bit        v;
    bit        pred;
    bit        act;
    bit [31:0] pc;
    bit [31:0] tgt;
  } slot_t;

  slot_t  sE, sM;
  longint m_b32, m_m32, m_b4, m_m4;
  localparam longint MAX32 = 64'hFFFF_FFFF;
  localparam longint MAX4  = 15;

  function automatic slot_t empty_slot();
    slot_t s;
    s.v = 0; s.pred = 0; s.act = 0; s.pc = '0; s.tgt = '0;
    return s;
  endfunction

  function automatic bit model_mis();
    return sM.v && (sM.pred != sM.act);
  endfunction

  task automatic model_edge();
    bit    mis;
    slot_t nE, nM;
    mis = model_mis();
    if (rst) begin
      sE = empty_slot(); sM = empty_slot();
      m_b32 = 0; m_m32 = 0; m_b4 = 0; m_m4 = 0;
      return;
    end
    if (sM.v && !stallM) begin
      if (m_b32 < MAX32) m_b32++;
      if (m_b4  < MAX4)  m_b4++;
      if (mis) begin
        if (m_m32 < MAX32) m_m32++;
        if (m_m4  < MAX4)  m_m4++;
      end
    end
    if (stallM)      nM = sM;
    else if (mis)    nM = empty_slot();
    else begin
      nM = sE;
      nM.act = sE.v && condE;
    end
    if (mis || flushE)          nE = empty_slot();
    else if (stallE || stallM)  nE = sE;
    else begin
      nE.v = branchD; nE.pred = branchD && pred_takeD; nE.act = 0;
      nE.pc = pcD; nE.tgt = targetD;
    end
    sE = nE; sM = nM;
  endtask

  task automatic compare_all();
    bit        mis;
    bit [31:0] rpc;
    mis = model_mis();
    rpc = sM.act ? sM.tgt : sM.pc + 32'd4;
    check("branchM",      bus32.branchM,      sM.v);
    check("pred_takeM",   bus32.pred_takeM,   sM.pred);
    check("actual_takeM", bus32.actual_takeM, sM.act);
    check("pcM",          bus32.pcM,          sM.pc);
    check("mispredM",     bus32.mispredM,     mis);
    check("flush_predD",  bus32.flush_predD,  mis);
    check("flush_predE",  bus32.flush_predE,  mis);
    if (mis) check("redirect_pcM", bus32.redirect_pcM, rpc);
    check("branch_cnt32",  bus32.branch_cnt,  m_b32);
    check("mispred_cnt32", bus32.mispred_cnt, m_m32);
    check("mispredM4",     bus4.mispredM,     mis);
    check("branch_cnt4",   bus4.branch_cnt,   m_b4);
    check("mispred_cnt4",  bus4.mispred_cnt,  m_m4);
  endtask

  task automatic step(input bit r, input bit bd, input bit pt, input logic [31:0] pc,
                      input logic [31:0] tg, input bit se, input bit sm, input bit fe,
                      input bit ce);
    rst = r; branchD = bd; pred_takeD = pt; pcD = pc; targetD = tg;
    stallE = se; stallM = sm; flushE = fe; condE = ce;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input bit ce);
    step(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, ce);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
    step(1, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
  endtask

  logic [31:0] b0, m0;

  initial begin
    sE = empty_slot(); sM = empty_slot();
    m_b32 = 0; m_m32 = 0; m_b4 = 0; m_m4 = 0;
    rst = 1; branchD = 0; pred_takeD = 0; pcD = 0; targetD = 0;
    stallE = 0; stallM = 0; flushE = 0; condE = 0;

    do_reset();
    check("rst_redirect", bus32.redirect_pcM, 32'h0);
    check("rst_bcnt",     bus32.branch_cnt,   32'h0);

    // Correctly predicted taken branch
    step(0, 1, 1, 32'h100, 32'h200, 0, 0, 0, 0);
    idle(1);
    check("t1_branchM", bus32.branchM,  1'b1);
    check("t1_pcM",     bus32.pcM,      32'h100);
    check("t1_mispred", bus32.mispredM, 1'b0);
    idle(0);
    check("t1_bcnt", bus32.branch_cnt,  32'd1);
    check("t1_mcnt", bus32.mispred_cnt, 32'd0);

    // Predicted taken, actually not taken
    do_reset();
    step(0, 1, 1, 32'h100, 32'h200, 0, 0, 0, 0);
    idle(0);
    check("t2_mispred",  bus32.mispredM,     1'b1);
    check("t2_redirect", bus32.redirect_pcM, 32'h104);
    check("t2_flushD",   bus32.flush_predD,  1'b1);
    check("t2_flushE",   bus32.flush_predE,  1'b1);
    step(0, 1, 1, 32'h300, 32'h400, 0, 0, 0, 0);   // squashed by the flush
    check("t2_bubble", bus32.branchM,     1'b0);
    check("t2_mcnt",   bus32.mispred_cnt, 32'd1);
    idle(1);
    check("t2_de_clr", bus32.branchM, 1'b0);

    // Predicted not taken, actually taken
    do_reset();
    step(0, 1, 0, 32'h40, 32'h80, 0, 0, 0, 0);
    idle(1);
    check("t3_mispred",  bus32.mispredM,     1'b1);
    check("t3_redirect", bus32.redirect_pcM, 32'h80);

    // Mispredicted branch held in M for three cycles
    do_reset();
    step(0, 1, 1, 32'h500, 32'h600, 0, 0, 0, 0);
    idle(0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 32'h0, 32'h0, 0, 1, 0, 0);
      check("t4_flush_hold", bus32.flush_predD, 1'b1);
      check("t4_mcnt_hold",  bus32.mispred_cnt, 32'd0);
    end
    idle(0);
    check("t4_mcnt", bus32.mispred_cnt, 32'd1);
    idle(0);
    check("t4_mcnt_once", bus32.mispred_cnt, 32'd1);

    // Non-branch with a stray taken prediction
    do_reset();
    step(0, 0, 1, 32'h700, 32'h800, 0, 0, 0, 0);
    idle(1);
    check("t5_branchM", bus32.branchM,    1'b0);
    check("t5_mispred", bus32.mispredM,   1'b0);
    idle(1);
    check("t5_bcnt",    bus32.branch_cnt, 32'd0);

    // Saturation of the narrow counters
    do_reset();
    for (int i = 0; i < 80; i++) step(0, 1, 1, 32'h1000 + 32'(i*4), 32'h2000, 0, 0, 0, 0);
    check("sat_bcnt4", bus4.branch_cnt,  4'hF);
    check("sat_mcnt4", bus4.mispred_cnt, 4'hF);

    // Reset with a branch in E
    step(0, 1, 1, 32'h900, 32'hA00, 0, 0, 0, 0);
    step(1, 1, 1, 32'h904, 32'hA00, 1, 1, 1, 1);
    check("rst_branchM",  bus32.branchM,      1'b0);
    check("rst_pcM",      bus32.pcM,          32'h0);
    check("rst_redir2",   bus32.redirect_pcM, 32'h0);
    check("rst_bcnt2",    bus32.branch_cnt,   32'h0);
    check("rst_mcnt4",    bus4.mispred_cnt,   4'h0);
    idle(0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      b0 = $urandom; m0 = $urandom;
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1,
           b0, m0, ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 2),
           ($urandom_range(0, 9) == 0), $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
